axil_dp_ram_adapt: RTL and testbench
====================================

AXIL_DP_RAM_ADAPT -- requirements
Module: axil_dp_ram_adapt

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, byte-address width of both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, native RAM word and port A data width.
REQ-003 SHALL have parameter DATA_WIDTH_EXT, default 32, port B data width; RATIO = DATA_WIDTH_EXT/DATA_WIDTH SHALL be a power of two from 1 to 8, else elaboration error.
REQ-004 SHALL have parameters STRB_WIDTH = DATA_WIDTH/8 and STRB_WIDTH_EXT = DATA_WIDTH_EXT/8.
REQ-005 SHALL have parameter PIPELINE_OUTPUT, default 0; 1 adds one output register stage on both read paths.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk input 1 is the single clock; rst input 1 is the synchronous active-high reset.
REQ-007 SHALL have port A AXI-Lite slave s_axil_a_*: aw(addr ADDR_WIDTH, prot 3, valid, ready), w(data DATA_WIDTH, strb STRB_WIDTH, valid, ready), b(resp 2, valid, ready), ar(addr, prot, valid, ready), r(data DATA_WIDTH, resp 2, valid, ready).
REQ-008 SHALL have port B AXI-Lite slave s_axil_b_* with the same signal set, using DATA_WIDTH_EXT data and STRB_WIDTH_EXT strobe.

Function
REQ-009 SHALL hold 2**(ADDR_WIDTH-log2(STRB_WIDTH)) words of DATA_WIDTH; port A word index = addr >> log2(STRB_WIDTH).
REQ-010 Port A write SHALL complete when awvalid and wvalid are both high and no bvalid is pending; awready and wready pulse together; byte-strobed write at that edge; bvalid is asserted the next cycle and held until bready.
REQ-011 Port A read SHALL assert arready when no rvalid is pending; rvalid follows 1 cycle after handshake (2 if PIPELINE_OUTPUT); rdata is held stable until rready.
REQ-012 Port B SHALL implement an FSM with states IDLE, WRITE, WRESP, READ, RRESP.
REQ-013 Port B base index SHALL be the port A-style index with the low log2(RATIO) bits cleared; address bits below STRB_WIDTH_EXT alignment are ignored.
REQ-014 In IDLE with awvalid and wvalid both high, port B SHALL assert awready and wready for one cycle (cycle T), latch data and strobe, and enter WRITE; write has priority over a simultaneous arvalid.
REQ-015 In WRITE, beat k (k = 0..RATIO-1, cycle T+1+k) SHALL write sub-word k (bits k*DATA_WIDTH upward) to base+k using strobe slice k; all-zero slices still consume a cycle.
REQ-016 After the last beat, port B SHALL enter WRESP; bvalid is asserted from cycle T+RATIO+1 and held until bready, then the FSM returns to IDLE.
REQ-017 In IDLE with arvalid and no write pending, port B SHALL pulse arready (cycle T) and enter READ, issuing RATIO word reads at base+k in cycles T+1..T+RATIO and assembling sub-word k into lane k.
REQ-018 Port B rvalid SHALL assert at cycle T+RATIO+1 (T+RATIO+2 if PIPELINE_OUTPUT); rdata is held until rready, then the FSM returns to IDLE.
REQ-019 bresp and rresp on both ports SHALL always be 2'b00 (OKAY).
REQ-020 If both ports write the same word in the same cycle, the port A write SHALL win and the port B beat for that word is discarded.
REQ-021 A read and a write to the same word in the same cycle SHALL return the old data (read-before-write).
REQ-022 When RATIO = 1, port B SHALL follow the same FSM with a single beat.
REQ-023 prot inputs SHALL be ignored.

Reset
REQ-024 On rst, all ready, bvalid and rvalid outputs SHALL be 0, rdata 0, and the port B FSM SHALL be in IDLE.
REQ-025 Reset mid-transaction SHALL abort it with no response; beats already written stay written; memory contents are not cleared.

Structure
REQ-026 Shared package axil_ram_pkg SHALL hold the RESP_OKAY constant, the port B FSM state enum and the clog2/ratio helper function.
REQ-027 Port B sequencing SHALL reside in one sub-module, axil_ram_portb_seq; the memory array and port A logic stay in the top module.

Verification (ADDR_WIDTH=9, DATA_WIDTH=16, DATA_WIDTH_EXT=32, PIPELINE_OUTPUT=0)
REQ-028 B write addr 0x010, data 0xDEADBEEF, strb 0xF -> bvalid at T+3; A read 0x010 = 0xBEEF, A read 0x012 = 0xDEAD.
REQ-029 A writes 0x1111@0x020 and 0x2222@0x022; B write 0x12345678@0x020 with strb 0xC -> B read 0x020 = 0x12341111, rvalid at T+3.
REQ-030 A writes 0xAAAA@0x040 in the same cycle as B beat 0 of 0xBBBBCCCC@0x040 -> A read 0x040 = 0xAAAA, A read 0x042 = 0xBBBB.
REQ-031 B read with rready low for 5 cycles -> rvalid and rdata stable, arready and awready low throughout; completes on rready.
REQ-032 rst asserted during B write beat 1 -> no bvalid and all outputs 0 the next cycle; a subsequent B write to 0x013 lands at 0x010/0x012.

Source files
------------

// File: rtl/axil_ram_pkg.sv
// Shared definitions for the dual-port AXI-Lite RAM adapter: response code,
// port B sequencer states and width helpers.
package axil_ram_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RRESP
  } portb_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Port B width must be a power-of-two multiple (1..8) of the native word.
  function automatic bit ratio_ok(input int unsigned dw, input int unsigned dwe);
    if (dw == 0 || (dwe % dw) != 0) return 1'b0;
    return (dwe / dw) inside {1, 2, 4, 8};
  endfunction

endpackage

// File: rtl/axil_ram_portb_seq.sv
// Port B sequencer: splits each wide AXI-Lite access into RATIO native-word
// beats against the shared RAM and assembles the wide read response.
module axil_ram_portb_seq
  import axil_ram_pkg::*;
#(
  parameter int ADDR_WIDTH      = 9,
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_WIDTH_EXT  = 32,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [ADDR_WIDTH-1:0]                              s_axil_awaddr,
  input  logic                                               s_axil_awvalid,
  output logic                                               s_axil_awready,
  input  logic [DATA_WIDTH_EXT-1:0]                          s_axil_wdata,
  input  logic [DATA_WIDTH_EXT/8-1:0]                        s_axil_wstrb,
  input  logic                                               s_axil_wvalid,
  output logic                                               s_axil_wready,
  output logic                                               s_axil_bvalid,
  input  logic                                               s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]                              s_axil_araddr,
  input  logic                                               s_axil_arvalid,
  output logic                                               s_axil_arready,
  output logic [DATA_WIDTH_EXT-1:0]                          s_axil_rdata,
  output logic                                               s_axil_rvalid,
  input  logic                                               s_axil_rready,
  output logic                                               mem_wr_en,
  output logic [ADDR_WIDTH-clog2(DATA_WIDTH/8)-1:0]          mem_idx,
  output logic [DATA_WIDTH-1:0]                              mem_wr_data,
  output logic [DATA_WIDTH/8-1:0]                            mem_wr_strb,
  input  logic [DATA_WIDTH-1:0]                              mem_rd_data
);

  localparam int unsigned STRB_WIDTH     = DATA_WIDTH / 8;
  localparam int unsigned STRB_WIDTH_EXT = DATA_WIDTH_EXT / 8;
  localparam int unsigned RATIO          = DATA_WIDTH_EXT / DATA_WIDTH;
  localparam int unsigned SHIFT          = clog2(STRB_WIDTH);
  localparam int unsigned IDX_W          = ADDR_WIDTH - SHIFT;
  localparam int unsigned RSH            = clog2(RATIO);
  localparam int unsigned BEAT_W         = (RSH > 0) ? RSH : 1;
  localparam logic [IDX_W-1:0] BASE_MASK = ~IDX_W'((1 << RSH) - 1);

  portb_state_t state, next_state;

  logic [IDX_W-1:0]          base_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [DATA_WIDTH_EXT-1:0] wdata_q;
  logic [STRB_WIDTH_EXT-1:0] wstrb_q;
  logic [DATA_WIDTH_EXT-1:0] asm_q;
  logic [DATA_WIDTH_EXT-1:0] out_q;
  logic                      out_valid_q;
  logic                      last_beat;
  logic                      wr_start;
  logic                      rd_start;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^{s_axil_awaddr, s_axil_araddr};

  function automatic logic [IDX_W-1:0] base_of(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:SHIFT] & BASE_MASK;
  endfunction

  assign last_beat   = (beat_q == BEAT_W'(RATIO - 1));
  assign mem_idx     = base_q | IDX_W'(beat_q);
  assign mem_wr_data = wdata_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
  assign mem_wr_strb = wstrb_q[beat_q*STRB_WIDTH +: STRB_WIDTH];

  assign s_axil_bvalid = (state == WRESP);
  assign s_axil_rvalid = out_valid_q;
  assign s_axil_rdata  = (PIPELINE_OUTPUT != 0) ? out_q : asm_q;

  always_comb begin
    next_state     = state;
    wr_start       = 1'b0;
    rd_start       = 1'b0;
    mem_wr_en      = 1'b0;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_arready = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (s_axil_awvalid && s_axil_wvalid) begin
            wr_start       = 1'b1;
            s_axil_awready = 1'b1;
            s_axil_wready  = 1'b1;
            next_state     = WRITE;
          end else if (s_axil_arvalid) begin
            rd_start       = 1'b1;
            s_axil_arready = 1'b1;
            next_state     = READ;
          end
        end
        WRITE: begin
          mem_wr_en = 1'b1;
          if (last_beat) next_state = WRESP;
        end
        WRESP: if (s_axil_bready) next_state = IDLE;
        READ:  if (last_beat) next_state = RRESP;
        RRESP: if (out_valid_q && s_axil_rready) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      beat_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE) beat_q <= '0;
      else if (state == WRITE || state == READ) beat_q <= beat_q + 1'b1;
      if (wr_start) begin
        base_q  <= base_of(s_axil_awaddr);
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end else if (rd_start) begin
        base_q <= base_of(s_axil_araddr);
      end
      if (state == READ) begin
        asm_q[beat_q*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
        if (last_beat && PIPELINE_OUTPUT == 0) out_valid_q <= 1'b1;
      end
      // Pipelined mode spends the first RRESP cycle moving the assembly into the output stage.
      if (state == RRESP) begin
        if (out_valid_q && s_axil_rready) begin
          out_valid_q <= 1'b0;
        end else if (!out_valid_q) begin
          out_q       <= asm_q;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axil_dp_ram_adapt.sv
// Dual-port AXI-Lite RAM: port A at native width, port B at a wider width
// sequenced into native-word beats. Port A wins same-word write collisions.
module axil_dp_ram_adapt
  import axil_ram_pkg::*;
#(
  parameter int ADDR_WIDTH      = 9,
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_WIDTH_EXT  = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int STRB_WIDTH_EXT  = DATA_WIDTH_EXT / 8,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_axil_a_awaddr,
  input  logic [2:0]                s_axil_a_awprot,
  input  logic                      s_axil_a_awvalid,
  output logic                      s_axil_a_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_a_wdata,
  input  logic [STRB_WIDTH-1:0]     s_axil_a_wstrb,
  input  logic                      s_axil_a_wvalid,
  output logic                      s_axil_a_wready,
  output logic [1:0]                s_axil_a_bresp,
  output logic                      s_axil_a_bvalid,
  input  logic                      s_axil_a_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_a_araddr,
  input  logic [2:0]                s_axil_a_arprot,
  input  logic                      s_axil_a_arvalid,
  output logic                      s_axil_a_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_a_rdata,
  output logic [1:0]                s_axil_a_rresp,
  output logic                      s_axil_a_rvalid,
  input  logic                      s_axil_a_rready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_b_awaddr,
  input  logic [2:0]                s_axil_b_awprot,
  input  logic                      s_axil_b_awvalid,
  output logic                      s_axil_b_awready,
  input  logic [DATA_WIDTH_EXT-1:0] s_axil_b_wdata,
  input  logic [STRB_WIDTH_EXT-1:0] s_axil_b_wstrb,
  input  logic                      s_axil_b_wvalid,
  output logic                      s_axil_b_wready,
  output logic [1:0]                s_axil_b_bresp,
  output logic                      s_axil_b_bvalid,
  input  logic                      s_axil_b_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_b_araddr,
  input  logic [2:0]                s_axil_b_arprot,
  input  logic                      s_axil_b_arvalid,
  output logic                      s_axil_b_arready,
  output logic [DATA_WIDTH_EXT-1:0] s_axil_b_rdata,
  output logic [1:0]                s_axil_b_rresp,
  output logic                      s_axil_b_rvalid,
  input  logic                      s_axil_b_rready
);

  localparam int unsigned SHIFT = clog2(STRB_WIDTH);
  localparam int unsigned IDX_W = ADDR_WIDTH - SHIFT;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  if (!ratio_ok(DATA_WIDTH, DATA_WIDTH_EXT)) begin : g_bad_ratio
    $error("axil_dp_ram_adapt: DATA_WIDTH_EXT/DATA_WIDTH must be 1, 2, 4 or 8");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      a_widx, a_ridx, b_idx;
  logic                  a_wr, a_rd;
  logic                  a_bvalid_q, a_rvalid_q, a_pipe_valid_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_pipe_data_q;
  logic                  b_wr_en;
  logic [DATA_WIDTH-1:0] b_wr_data, b_rd_data;
  logic [STRB_WIDTH-1:0] b_wr_strb;
  logic                  unused_inputs;

  assign unused_inputs = ^{s_axil_a_awprot, s_axil_a_arprot, s_axil_b_awprot,
                           s_axil_b_arprot, s_axil_a_awaddr, s_axil_a_araddr};

  assign a_widx = s_axil_a_awaddr[ADDR_WIDTH-1:SHIFT];
  assign a_ridx = s_axil_a_araddr[ADDR_WIDTH-1:SHIFT];
  assign a_wr   = !rst && s_axil_a_awvalid && s_axil_a_wvalid && !a_bvalid_q;
  assign a_rd   = !rst && s_axil_a_arvalid && !a_rvalid_q && !a_pipe_valid_q;

  assign s_axil_a_awready = a_wr;
  assign s_axil_a_wready  = a_wr;
  assign s_axil_a_arready = a_rd;
  assign s_axil_a_bvalid  = a_bvalid_q;
  assign s_axil_a_rvalid  = a_rvalid_q;
  assign s_axil_a_rdata   = a_rdata_q;
  assign s_axil_a_bresp   = RESP_OKAY;
  assign s_axil_a_rresp   = RESP_OKAY;
  assign s_axil_b_bresp   = RESP_OKAY;
  assign s_axil_b_rresp   = RESP_OKAY;

  // Reads are combinational from the array and captured at the edge, so a
  // same-cycle write to the same word is seen only by later reads.
  assign b_rd_data = mem[b_idx];

  always_ff @(posedge clk) begin
    if (b_wr_en && !(a_wr && a_widx == b_idx)) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++)
        if (b_wr_strb[i]) mem[b_idx][i*8 +: 8] <= b_wr_data[i*8 +: 8];
    end
    if (a_wr) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++)
        if (s_axil_a_wstrb[i]) mem[a_widx][i*8 +: 8] <= s_axil_a_wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_bvalid_q     <= 1'b0;
      a_rvalid_q     <= 1'b0;
      a_pipe_valid_q <= 1'b0;
      a_rdata_q      <= '0;
      a_pipe_data_q  <= '0;
    end else begin
      if (a_wr) a_bvalid_q <= 1'b1;
      else if (s_axil_a_bready) a_bvalid_q <= 1'b0;
      if (a_rvalid_q && s_axil_a_rready) a_rvalid_q <= 1'b0;
      if (PIPELINE_OUTPUT != 0) begin
        a_pipe_valid_q <= a_rd;
        if (a_rd) a_pipe_data_q <= mem[a_ridx];
        if (a_pipe_valid_q) begin
          a_rdata_q  <= a_pipe_data_q;
          a_rvalid_q <= 1'b1;
        end
      end else if (a_rd) begin
        a_rdata_q  <= mem[a_ridx];
        a_rvalid_q <= 1'b1;
      end
    end
  end

  axil_ram_portb_seq #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .DATA_WIDTH_EXT  (DATA_WIDTH_EXT),
    .PIPELINE_OUTPUT (PIPELINE_OUTPUT)
  ) u_portb_seq (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_axil_b_awaddr),
    .s_axil_awvalid (s_axil_b_awvalid),
    .s_axil_awready (s_axil_b_awready),
    .s_axil_wdata   (s_axil_b_wdata),
    .s_axil_wstrb   (s_axil_b_wstrb),
    .s_axil_wvalid  (s_axil_b_wvalid),
    .s_axil_wready  (s_axil_b_wready),
    .s_axil_bvalid  (s_axil_b_bvalid),
    .s_axil_bready  (s_axil_b_bready),
    .s_axil_araddr  (s_axil_b_araddr),
    .s_axil_arvalid (s_axil_b_arvalid),
    .s_axil_arready (s_axil_b_arready),
    .s_axil_rdata   (s_axil_b_rdata),
    .s_axil_rvalid  (s_axil_b_rvalid),
    .s_axil_rready  (s_axil_b_rready),
    .mem_wr_en      (b_wr_en),
    .mem_idx        (b_idx),
    .mem_wr_data    (b_wr_data),
    .mem_wr_strb    (b_wr_strb),
    .mem_rd_data    (b_rd_data)
  );

endmodule

// File: tb/tb_axil_dp_ram_adapt.sv
// Directed bench for axil_dp_ram_adapt (16-bit port A, 32-bit port B).
module tb_axil_dp_ram_adapt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [8:0]  a_awaddr = '0, a_araddr = '0, b_awaddr = '0, b_araddr = '0;
  logic [2:0]  a_awprot = '0, a_arprot = '0, b_awprot = '0, b_arprot = '0;
  logic        a_awvalid = 0, a_wvalid = 0, a_bready = 0, a_arvalid = 0, a_rready = 0;
  logic        b_awvalid = 0, b_wvalid = 0, b_bready = 0, b_arvalid = 0, b_rready = 0;
  logic [15:0] a_wdata = '0;
  logic [1:0]  a_wstrb = '0;
  logic [31:0] b_wdata = '0;
  logic [3:0]  b_wstrb = '0;
  logic        a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0]  a_bresp, a_rresp, b_bresp, b_rresp;
  logic [15:0] a_rdata;
  logic [31:0] b_rdata;

  axil_dp_ram_adapt #(
    .ADDR_WIDTH(9), .DATA_WIDTH(16), .DATA_WIDTH_EXT(32), .PIPELINE_OUTPUT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_a_awaddr(a_awaddr), .s_axil_a_awprot(a_awprot), .s_axil_a_awvalid(a_awvalid),
    .s_axil_a_awready(a_awready), .s_axil_a_wdata(a_wdata), .s_axil_a_wstrb(a_wstrb),
    .s_axil_a_wvalid(a_wvalid), .s_axil_a_wready(a_wready), .s_axil_a_bresp(a_bresp),
    .s_axil_a_bvalid(a_bvalid), .s_axil_a_bready(a_bready), .s_axil_a_araddr(a_araddr),
    .s_axil_a_arprot(a_arprot), .s_axil_a_arvalid(a_arvalid), .s_axil_a_arready(a_arready),
    .s_axil_a_rdata(a_rdata), .s_axil_a_rresp(a_rresp), .s_axil_a_rvalid(a_rvalid),
    .s_axil_a_rready(a_rready),
    .s_axil_b_awaddr(b_awaddr), .s_axil_b_awprot(b_awprot), .s_axil_b_awvalid(b_awvalid),
    .s_axil_b_awready(b_awready), .s_axil_b_wdata(b_wdata), .s_axil_b_wstrb(b_wstrb),
    .s_axil_b_wvalid(b_wvalid), .s_axil_b_wready(b_wready), .s_axil_b_bresp(b_bresp),
    .s_axil_b_bvalid(b_bvalid), .s_axil_b_bready(b_bready), .s_axil_b_araddr(b_araddr),
    .s_axil_b_arprot(b_arprot), .s_axil_b_arvalid(b_arvalid), .s_axil_b_arready(b_arready),
    .s_axil_b_rdata(b_rdata), .s_axil_b_rresp(b_rresp), .s_axil_b_rvalid(b_rvalid),
    .s_axil_b_rready(b_rready)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic a_write(input logic [8:0] addr, input logic [15:0] data,
                         input logic [1:0] strb, output int lat);
    int n;
    @(posedge clk); #1;
    a_awaddr = addr; a_wdata = data; a_wstrb = strb; a_awvalid = 1; a_wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(a_awready && a_wready) && n < 50);
    if (n >= 50) chk("a_write_hs_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_awvalid = 0; a_wvalid = 0; a_bready = 1;
    lat = 1;
    @(negedge clk);
    while (!a_bvalid && lat < 50) begin @(negedge clk); lat++; end
    chk("a_bresp", {30'd0, a_bresp}, 32'd0);
    @(posedge clk); #1; a_bready = 0;
  endtask

  task automatic a_read(input logic [8:0] addr, output logic [15:0] data, output int lat);
    int n;
    @(posedge clk); #1;
    a_araddr = addr; a_arvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_arready && n < 50);
    if (n >= 50) chk("a_read_hs_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_arvalid = 0; a_rready = 1;
    lat = 1;
    @(negedge clk);
    while (!a_rvalid && lat < 50) begin @(negedge clk); lat++; end
    data = a_rdata;
    @(posedge clk); #1; a_rready = 0;
  endtask

  task automatic b_write(input logic [8:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output int lat);
    int n;
    @(posedge clk); #1;
    b_awaddr = addr; b_wdata = data; b_wstrb = strb; b_awvalid = 1; b_wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(b_awready && b_wready) && n < 50);
    if (n >= 50) chk("b_write_hs_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    b_awvalid = 0; b_wvalid = 0; b_bready = 1;
    lat = 1;
    @(negedge clk);
    while (!b_bvalid && lat < 50) begin @(negedge clk); lat++; end
    chk("b_bresp", {30'd0, b_bresp}, 32'd0);
    @(posedge clk); #1; b_bready = 0;
  endtask

  task automatic b_read(input logic [8:0] addr, output logic [31:0] data, output int lat);
    int n;
    @(posedge clk); #1;
    b_araddr = addr; b_arvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_arready && n < 50);
    if (n >= 50) chk("b_read_hs_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    b_arvalid = 0; b_rready = 1;
    lat = 1;
    @(negedge clk);
    while (!b_rvalid && lat < 50) begin @(negedge clk); lat++; end
    data = b_rdata;
    @(posedge clk); #1; b_rready = 0;
  endtask

  typedef enum int {A_WR, A_RD, B_WR, B_RD} op_t;
  typedef struct {
    op_t         op;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] all_outputs();
    return {22'd0, a_awready, a_wready, a_bvalid, a_arready, a_rvalid,
            b_awready, b_wready, b_bvalid, b_arready, b_rvalid};
  endfunction

  initial begin
    logic [15:0] ad;
    logic [31:0] bd;
    int lat;
    int n;

    vecs.push_back('{B_WR, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0,        3});
    vecs.push_back('{A_RD, 9'h010, 32'h0,        4'h0, 32'hBEEF,     1});
    vecs.push_back('{A_RD, 9'h012, 32'h0,        4'h0, 32'hDEAD,     1});
    vecs.push_back('{A_WR, 9'h020, 32'h1111,     4'h3, 32'h0,        1});
    vecs.push_back('{A_WR, 9'h022, 32'h2222,     4'h3, 32'h0,        1});
    vecs.push_back('{B_WR, 9'h020, 32'h12345678, 4'hC, 32'h0,        3});
    vecs.push_back('{B_RD, 9'h020, 32'h0,        4'h0, 32'h12341111, 3});
    vecs.push_back('{A_WR, 9'h050, 32'h1234,     4'h3, 32'h0,        1});
    vecs.push_back('{A_WR, 9'h050, 32'hABCD,     4'h2, 32'h0,        1});
    vecs.push_back('{A_RD, 9'h050, 32'h0,        4'h0, 32'hAB34,     1});
    vecs.push_back('{B_WR, 9'h060, 32'hCAFEF00D, 4'hF, 32'h0,        3});
    vecs.push_back('{B_RD, 9'h062, 32'h0,        4'h0, 32'hCAFEF00D, 3});
    vecs.push_back('{A_RD, 9'h062, 32'h0,        4'h0, 32'hCAFE,     1});
    vecs.push_back('{B_WR, 9'h060, 32'h11223344, 4'h0, 32'h0,        3});
    vecs.push_back('{B_RD, 9'h060, 32'h0,        4'h0, 32'hCAFEF00D, 3});
    vecs.push_back('{B_WR, 9'h061, 32'h11223344, 4'h5, 32'h0,        3});
    vecs.push_back('{B_RD, 9'h060, 32'h0,        4'h0, 32'hCA22F044, 3});
    vecs.push_back('{B_WR, 9'h1FC, 32'h0BADC0DE, 4'hF, 32'h0,        3});
    vecs.push_back('{A_RD, 9'h1FE, 32'h0,        4'h0, 32'h0BAD,     1});
    vecs.push_back('{B_RD, 9'h1FF, 32'h0,        4'h0, 32'h0BADC0DE, 3});

    // Reset: all handshake outputs low, even with every valid raised.
    repeat (2) @(posedge clk);
    #1;
    a_awvalid = 1; a_wvalid = 1; a_arvalid = 1; b_awvalid = 1; b_wvalid = 1; b_arvalid = 1;
    @(negedge clk);
    chk("rst_flags", all_outputs(), 32'd0);
    chk("rst_a_rdata", {16'd0, a_rdata}, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_resp", {28'd0, a_bresp, b_rresp}, 32'd0);
    @(posedge clk); #1;
    a_awvalid = 0; a_wvalid = 0; a_arvalid = 0; b_awvalid = 0; b_wvalid = 0; b_arvalid = 0;
    rst = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        A_WR: a_write(vecs[i].addr, vecs[i].data[15:0], vecs[i].strb[1:0], lat);
        A_RD: begin
          a_read(vecs[i].addr, ad, lat);
          chk($sformatf("vec%0d_a_rdata", i), {16'd0, ad}, vecs[i].exp);
        end
        B_WR: b_write(vecs[i].addr, vecs[i].data, vecs[i].strb, lat);
        default: begin
          b_read(vecs[i].addr, bd, lat);
          chk($sformatf("vec%0d_b_rdata", i), bd, vecs[i].exp);
        end
      endcase
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Same-word write collision: A handshake lands on B's beat 0.
    @(posedge clk); #1;
    b_awaddr = 9'h040; b_wdata = 32'hBBBBCCCC; b_wstrb = 4'hF; b_awvalid = 1; b_wvalid = 1;
    @(negedge clk);
    chk("coll_b_hs", {31'd0, b_awready & b_wready}, 32'd1);
    @(posedge clk); #1;
    b_awvalid = 0; b_wvalid = 0;
    a_awaddr = 9'h040; a_wdata = 16'hAAAA; a_wstrb = 2'b11; a_awvalid = 1; a_wvalid = 1;
    @(negedge clk);
    chk("coll_a_hs", {31'd0, a_awready & a_wready}, 32'd1);
    @(posedge clk); #1;
    a_awvalid = 0; a_wvalid = 0; a_bready = 1; b_bready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_bvalid && n < 50);
    chk("coll_b_bvalid", {31'd0, b_bvalid}, 32'd1);
    @(posedge clk); #1; a_bready = 0; b_bready = 0;
    a_read(9'h040, ad, lat);
    chk("coll_a_wins", {16'd0, ad}, 32'h0000AAAA);
    a_read(9'h042, ad, lat);
    chk("coll_b_hi", {16'd0, ad}, 32'h0000BBBB);

    // B read held off by rready while other B requests are pending.
    @(posedge clk); #1;
    b_araddr = 9'h020; b_arvalid = 1;
    @(negedge clk);
    chk("stall_ar_hs", {31'd0, b_arready}, 32'd1);
    @(posedge clk); #1;
    b_arvalid = 0;
    lat = 1;
    @(negedge clk);
    while (!b_rvalid && lat < 50) begin @(negedge clk); lat++; end
    chk("stall_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      b_awaddr = 9'h100; b_wdata = 32'h0; b_wstrb = 4'hF;
      b_awvalid = 1; b_wvalid = 1; b_arvalid = 1;
      @(negedge clk);
      chk($sformatf("stall%0d_rvalid", i), {31'd0, b_rvalid}, 32'd1);
      chk($sformatf("stall%0d_rdata", i), b_rdata, 32'h12341111);
      chk($sformatf("stall%0d_readies", i), {29'd0, b_arready, b_awready, b_wready}, 32'd0);
    end
    @(posedge clk); #1;
    b_awvalid = 0; b_wvalid = 0; b_arvalid = 0; b_rready = 1;
    @(negedge clk);
    chk("stall_release_rvalid", {31'd0, b_rvalid}, 32'd1);
    @(posedge clk); #1; b_rready = 0;
    @(negedge clk);
    chk("stall_done_rvalid", {31'd0, b_rvalid}, 32'd0);

    // Reset during B write beat 1 aborts with no response.
    @(posedge clk); #1;
    b_awaddr = 9'h030; b_wdata = 32'h55556666; b_wstrb = 4'hF; b_awvalid = 1; b_wvalid = 1;
    @(negedge clk);
    chk("abort_hs", {31'd0, b_awready & b_wready}, 32'd1);
    @(posedge clk); #1;
    b_awvalid = 0; b_wvalid = 0;
    @(posedge clk); #1;
    rst = 1; b_bready = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_flags", all_outputs(), 32'd0);
    chk("abort_rdata", {a_rdata, b_rdata[15:0]} | {16'd0, b_rdata[31:16]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_no_bvalid%0d", i), {31'd0, b_bvalid}, 32'd0);
    end
    @(posedge clk); #1; b_bready = 0;
    b_write(9'h013, 32'h9ABCDEF0, 4'hF, lat);
    chk("post_rst_latency", lat, 3);
    a_read(9'h010, ad, lat);
    chk("post_rst_lo", {16'd0, ad}, 32'h0000DEF0);
    a_read(9'h012, ad, lat);
    chk("post_rst_hi", {16'd0, ad}, 32'h00009ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
